// File: rtl/r_rom_pkg.sv
// Shared types and constants for the boot-ROM arbiter slice.
package r_rom_pkg;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 64;
   localparam int SIZE_W      = 3;
   localparam int SRC_W       = 4;
   localparam int OPC_W       = 3;
   localparam int TIMEOUT_DEF = 4096;

   localparam logic [OPC_W-1:0] TL_GET             = 3'd4;
   localparam logic [OPC_W-1:0] TL_ACCESS_ACK_DATA = 3'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;
endpackage

// File: rtl/r_rom_arbiter_if.sv
// TileLink-UL subset (A and D channels) used between requesters, arbiter and ROM frontend.
interface tilelink;
   import r_rom_pkg::*;

   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_address;
   logic [SIZE_W-1:0] a_size;
   logic [SRC_W-1:0]  a_source;
   logic [OPC_W-1:0]  a_opcode;
   logic              d_valid;
   logic              d_ready;
   logic [DATA_W-1:0] d_data;
   logic [SIZE_W-1:0] d_size;
   logic [SRC_W-1:0]  d_source;
   logic [OPC_W-1:0]  d_opcode;
   logic              d_denied;

   modport master (
      output a_valid, a_address, a_size, a_source, a_opcode, d_ready,
      input  a_ready, d_valid, d_data, d_size, d_source, d_opcode, d_denied
   );
   modport slave (
      input  a_valid, a_address, a_size, a_source, a_opcode, d_ready,
      output a_ready, d_valid, d_data, d_size, d_source, d_opcode, d_denied
   );
endinterface

// File: rtl/dff.sv
// Register with synchronous clear taking priority over enable.
module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     o_q <= '0;
      else if (i_clr) o_q <= '0;
      else if (i_en)  o_q <= i_d;
   end
endmodule

// File: rtl/r_rom_arbiter_arb2.sv
// Two-way round-robin grant; o_last remembers the most recent winner (1 = port 1).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_gnt,
   output logic       o_last
);
   logic r_last;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   // Reset to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_last <= 1'b1;
      else if (i_advance && (o_gnt != 2'b00)) r_last <= o_gnt[1];
   end

   assign o_last = r_last;
endmodule

// File: rtl/r_rom_arbiter.sv
// Shares one ROM TileLink slave between fetch (req0) and loader (req1), one transaction at a time.
module r_rom_arbiter
   import r_rom_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   tilelink.slave  req0,
   tilelink.slave  req1,
   tilelink.master rom
);
   state_t            r_state, w_next;
   logic [1:0]        w_gnt;
   logic              w_last;
   logic              w_idle, w_timeout, w_win_dready;
   logic              w_ardy0, w_ardy1, w_rom_av, w_rom_dr;
   logic [TO_W-1:0]   r_wdog, w_wdog_d;
   logic [ADDR_W-1:0] r_addr;
   logic [SIZE_W-1:0] r_size, r_d_size;
   logic [SRC_W-1:0]  r_src, r_d_src;
   logic [OPC_W-1:0]  r_opc, r_d_opc;
   logic [DATA_W-1:0] r_d_data;
   logic              r_d_denied;
   logic [1:0]        r_d_valid;

   assign w_idle = (r_state == S_IDLE);

   // Between grant and response the arbiter's last-winner bit is the current owner.
   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     ({req1.a_valid, req0.a_valid}),
      .i_advance (w_idle),
      .o_gnt     (w_gnt),
      .o_last    (w_last)
   );

   assign w_wdog_d = r_wdog + 1'b1;
   dff #(.W(TO_W)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (r_state == S_WAIT),
      .i_clr (r_state != S_WAIT),
      .i_d   (w_wdog_d),
      .o_q   (r_wdog)
   );
   assign w_timeout    = (r_wdog == TO_W'(TIMEOUT - 1));
   assign w_win_dready = w_last ? req1.d_ready : req0.d_ready;

   always_comb begin
      w_next   = r_state;
      w_ardy0  = 1'b0;
      w_ardy1  = 1'b0;
      w_rom_av = 1'b0;
      w_rom_dr = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ardy0  = w_gnt[0];
            w_ardy1  = w_gnt[1];
            w_rom_dr = rom.d_valid;
            if (w_gnt != 2'b00) w_next = S_REQ;
         end
         S_REQ: begin
            w_rom_av = 1'b1;
            if (rom.a_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            w_rom_dr = 1'b1;
            if (rom.d_valid || w_timeout) w_next = S_RESP;
         end
         S_RESP: begin
            if (w_win_dready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_size     <= '0;
         r_src      <= '0;
         r_opc      <= '0;
         r_d_data   <= '0;
         r_d_size   <= '0;
         r_d_src    <= '0;
         r_d_opc    <= '0;
         r_d_denied <= 1'b0;
         r_d_valid  <= 2'b00;
      end else begin
         r_state <= w_next;
         if (w_idle && (w_gnt != 2'b00)) begin
            r_addr <= w_gnt[1] ? req1.a_address : req0.a_address;
            r_size <= w_gnt[1] ? req1.a_size    : req0.a_size;
            r_src  <= w_gnt[1] ? req1.a_source  : req0.a_source;
            r_opc  <= w_gnt[1] ? req1.a_opcode  : req0.a_opcode;
         end
         // A real answer beats the watchdog when both land in the same cycle.
         if (r_state == S_WAIT && rom.d_valid) begin
            r_d_data   <= rom.d_data;
            r_d_size   <= rom.d_size;
            r_d_src    <= rom.d_source;
            r_d_opc    <= rom.d_opcode;
            r_d_denied <= rom.d_denied;
         end else if (r_state == S_WAIT && w_timeout) begin
            r_d_data   <= '0;
            r_d_size   <= r_size;
            r_d_src    <= r_src;
            r_d_opc    <= TL_ACCESS_ACK_DATA;
            r_d_denied <= 1'b1;
         end
         r_d_valid <= (w_next == S_RESP) ? {w_last, ~w_last} : 2'b00;
      end
   end

   assign req0.a_ready  = w_ardy0;
   assign req1.a_ready  = w_ardy1;
   assign req0.d_valid  = r_d_valid[0];
   assign req1.d_valid  = r_d_valid[1];
   assign req0.d_data   = r_d_data;
   assign req1.d_data   = r_d_data;
   assign req0.d_size   = r_d_size;
   assign req1.d_size   = r_d_size;
   assign req0.d_source = r_d_src;
   assign req1.d_source = r_d_src;
   assign req0.d_opcode = r_d_opc;
   assign req1.d_opcode = r_d_opc;
   assign req0.d_denied = r_d_denied;
   assign req1.d_denied = r_d_denied;

   assign rom.a_valid   = w_rom_av;
   assign rom.a_address = r_addr;
   assign rom.a_size    = r_size;
   assign rom.a_source  = r_src;
   assign rom.a_opcode  = r_opc;
   assign rom.d_ready   = w_rom_dr;
endmodule

// File: doc/r_rom_arbiter.md
Name: r_rom_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-serial boot-ROM frontend.
- Shares the single ROM TileLink slave between an instruction-fetch master (port 0) and a data/loader master (port 1), with one transaction outstanding at a time.
- Latches and holds request fields until the response arrives, buffers the response, and returns it to the winner.
- A watchdog returns a denied response if the ROM never answers.

Parameters:
- TIMEOUT, 4096: maximum cycles to wait for downstream d_valid before answering with a denied response; legal range 16..65535.
- TO_W, 16: width of the watchdog counter; must be at least clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset; one clock domain; asynchronous assert.
- req0  tilelink.slave  intf  requester 0 (fetch); signals used: a_valid/a_ready/a_address/a_size/a_source/a_opcode, d_valid/d_ready/d_data/d_size/d_source/d_opcode/d_denied.
- req1  tilelink.slave  intf  requester 1 (loader); same signal set as req0.
- rom  tilelink.master  intf  downstream ROM frontend slave.

Behaviour:
- Reset values:
  - reqN.a_ready=0, reqN.d_valid=0, reqN.d_data=0, reqN.d_denied=0.
  - rom.a_valid=0, rom.d_ready=0.
  - state=S_IDLE, last_grant=1, so port 0 wins the first tie.
  - All latched fields 0.
- S_IDLE:
  - Arbitration: if exactly one reqN.a_valid, grant it. If both, grant the port != last_grant (round-robin).
  - In the grant cycle, reqN.a_ready=1 (combinational) for the winner only; the loser sees a_ready=0.
  - On that edge: latch address, size, source, opcode and winner id; set last_grant; go to S_REQ.
  - No a_valid: stay in S_IDLE.
  - A stray rom.d_valid in S_IDLE (late answer after a timeout) is acked (rom.d_ready=1) and dropped.
- S_REQ:
  - rom.a_valid=1 for exactly one cycle, with latched address/size/source/opcode.
  - The downstream accepts unconditionally (a_ready is tied high there); go to S_WAIT and clear the watchdog.
- S_WAIT:
  - rom.a_address/a_size/a_source/a_opcode stay stable; the downstream samples a_size/a_source at response time.
  - rom.a_valid=0; watchdog increments each cycle.
  - rom.d_ready=1. When rom.d_valid=1: capture d_data, d_size, d_source, d_opcode, d_denied; go to S_RESP.
  - If the watchdog reaches TIMEOUT-1 with no d_valid:
    - Load d_data=0, d_denied=1, d_opcode=TL_ACCESS_ACK_DATA, d_size/d_source from the latched request.
    - Go to S_RESP.
  - If d_valid arrives in the same cycle as the timeout, d_valid wins.
- S_RESP:
  - winner.d_valid=1 with buffered fields, held stable until winner.d_ready=1.
  - On the handshake edge go to S_IDLE; the next grant is possible in the following cycle.
  - The non-winner's d_valid stays 0.
- Latency, no contention:
  - Winner a_valid at cycle 0 → rom.a_valid at cycle 1.
  - Downstream d_valid at cycle k → winner d_valid at cycle k+1.
- A requester holding a_valid across transactions with the other port also active alternates strictly: 0,1,0,1.
- A requester dropping a_valid before grant is not an error; no request is latched.
- Reset mid-transaction:
  - All state clears immediately, with no response to the upstream.
  - A late downstream response is dropped through the S_IDLE stray-ack rule.
- All d_* outputs are registered. a_ready and rom.d_ready are combinational from state.

Decomposition:
- Shared package r_rom_pkg:
  - State enum (S_IDLE, S_REQ, S_WAIT, S_RESP) as 2-bit localparams.
  - Default TIMEOUT.
  - TL_ACCESS_ACK_DATA and TL_GET from isa.vh.
- One natural sub-module: rr_arb2, a two-way round-robin grant with inputs req[1:0] and advance, and outputs gnt[1:0] and last.
- The watchdog counter uses the codebase dff with enable/clear.

Test Plan:
1. Reset, then req0 Get at 0x1000_0040, ROM returns 0x1122334455667788 after 20 cycles → req0.d_valid one cycle after rom.d_valid; d_data=0x1122334455667788, d_source echoed; req1.d_valid stays 0.
2. Both a_valid in the same cycle from reset (addr0=0x100, addr1=0x200) → req0 granted first (rom.a_address=0x100), req1 after req0's d handshake; then a third request from each → order 0,1,0,1.
3. req1 holds d_ready=0 for 5 cycles in S_RESP → d_valid and d_data stable all 5 cycles; no new rom.a_valid issued; completes on d_ready.
4. TIMEOUT=32, ROM never responds → winner gets d_valid 32 cycles after entering S_WAIT with d_denied=1, d_data=0; the late rom.d_valid at cycle 40 is acked and dropped; the next request proceeds normally.
5. rst_n low during S_WAIT → all outputs return to reset values asynchronously; after release, a new req0 Get completes with correct data.
6. rom.d_valid in exactly the timeout cycle → real data returned with d_denied as sent by the ROM, not a timeout response.
